// File: rtl/divu_arb.sv
// Round-robin arbiter/sequencer sharing one iterative unsigned divider among NREQ requesters.
// Optional watchdog on the divider done pulse: define DIVARB_TIMEOUT_EN.

module divu_arb_lane (
  input  logic idle,
  input  logic resp,
  input  logic gnt,
  input  logic own,
  input  logic rsp_ready,
  output logic req_ready,
  output logic rsp_valid,
  output logic rsp_hs
);
  assign req_ready = idle & gnt;
  assign rsp_valid = resp & own;
  assign rsp_hs    = rsp_valid & rsp_ready;
endmodule

module divu_arb #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 8,
  parameter int TMO_CYCLES = 2*WIDTH+4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_quo,
  output logic [WIDTH-1:0]      rsp_rem,
  output logic                  rsp_dbz,
  output logic                  rsp_err,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_a,
  output logic [WIDTH-1:0]      div_b,
  input  logic                  div_busy,
  input  logic                  div_done,
  input  logic                  div_dbz,
  input  logic [WIDTH-1:0]      div_val,
  input  logic [WIDTH-1:0]      div_rem
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dbz;
    logic             err;
  } rsp_t;

  state_t                      state, state_nx;
  logic [IW-1:0]               rr_ptr, owner, gnt_idx;
  logic                        gnt_any, tmo_hit;
  logic [IW:0]                 srch;
  logic [NREQ-1:0]             rsp_hs;
  logic [NREQ-1:0][WIDTH-1:0]  a_v, b_v;
  rsp_t                        rsp;

  assign a_v = req_a;
  assign b_v = req_b;

  assign rsp_quo = rsp.quo;
  assign rsp_rem = rsp.rem;
  assign rsp_dbz = rsp.dbz;
  assign rsp_err = rsp.err;

  // Rotating search starting at rr_ptr; first valid requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    srch    = '0;
    for (int i = 0; i < NREQ; i++) begin
      srch = {1'b0, rr_ptr} + (IW+1)'(i);
      if (srch >= (IW+1)'(NREQ)) srch = srch - (IW+1)'(NREQ);
      if (!gnt_any && req_valid[srch[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = srch[IW-1:0];
      end
    end
  end

  for (genvar k = 0; k < NREQ; k++) begin : g_lane
    divu_arb_lane u_lane (
      .idle      (state == IDLE),
      .resp      (state == RESP),
      .gnt       (gnt_any && (gnt_idx == IW'(k))),
      .own       (owner == IW'(k)),
      .rsp_ready (rsp_ready[k]),
      .req_ready (req_ready[k]),
      .rsp_valid (rsp_valid[k]),
      .rsp_hs    (rsp_hs[k])
    );
  end

`ifdef DIVARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES+1);
  logic [TW-1:0] tmo_cnt;

  // Counts cycles spent in WAIT; held at zero everywhere else.
  always_ff @(posedge clk) begin
    if (!rstn || state != WAIT) tmo_cnt <= '0;
    else                        tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_hit = (state == WAIT) && !div_done && (tmo_cnt == TW'(TMO_CYCLES-1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    case (state)
      IDLE:  if (gnt_any) state_nx = ISSUE;
      ISSUE: if (!div_busy) begin
        div_start = 1'b1;
        state_nx  = WAIT;
      end
      WAIT:  if (div_done || tmo_hit) state_nx = RESP;
      RESP:  if (|rsp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      div_a  <= '0;
      div_b  <= '0;
      rsp    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (gnt_any) begin
          owner <= gnt_idx;
          div_a <= a_v[gnt_idx];
          div_b <= b_v[gnt_idx];
        end
        WAIT: if (div_done) begin
          rsp.quo <= div_dbz ? '0 : div_val;
          rsp.rem <= div_dbz ? '0 : div_rem;
          rsp.dbz <= div_dbz;
          rsp.err <= 1'b0;
        end else if (tmo_hit) begin
          rsp <= '{quo: '0, rem: '0, dbz: 1'b0, err: 1'b1};
        end
        // Just-served requester drops to lowest priority.
        RESP: if (|rsp_hs) rr_ptr <= (owner == IW'(NREQ-1)) ? '0 : owner + IW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divu_arb.sv
// Directed bench for divu_arb with a behavioural iterative divider model.
// Define DIVARB_TIMEOUT_EN for both files to also exercise the watchdog.

module tb_divu_arb;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W-1:0]    req_a = '0;
  logic [NREQ*W-1:0]    req_b = '0;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready = '1;
  logic [W-1:0]         rsp_quo, rsp_rem;
  logic                 rsp_dbz, rsp_err;
  logic                 div_start;
  logic [W-1:0]         div_a, div_b;
  logic                 div_busy, div_done, div_dbz;
  logic [W-1:0]         div_val, div_rem;

  int   total = 0;
  int   bad   = 0;
  int   starts = 0;
  logic hang = 1'b0;
  logic [3:0] dcnt;

  divu_arb #(.NREQ(NREQ), .WIDTH(W), .TMO_CYCLES(20)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quo(rsp_quo), .rsp_rem(rsp_rem), .rsp_dbz(rsp_dbz), .rsp_err(rsp_err),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_done(div_done), .div_dbz(div_dbz),
    .div_val(div_val), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  // Divider: done WIDTH cycles after start is sampled, 1 cycle for b=0.
  always @(posedge clk) begin
    if (!rstn) begin
      div_busy <= 1'b0;
      div_done <= 1'b0;
      div_dbz  <= 1'b0;
      div_val  <= '0;
      div_rem  <= '0;
      dcnt     <= '0;
    end else begin
      div_done <= 1'b0;
      if (div_start && !div_busy) begin
        div_busy <= 1'b1;
        dcnt     <= (div_b == 0) ? 4'd0 : 4'(W-1);
        div_dbz  <= (div_b == 0);
        div_val  <= (div_b == 0) ? '1 : div_a / div_b;
        div_rem  <= (div_b == 0) ? div_a : div_a % div_b;
      end else if (div_busy) begin
        if (dcnt == 0) begin
          if (!hang) begin
            div_done <= 1'b1;
            div_busy <= 1'b0;
          end
        end else dcnt <= dcnt - 4'd1;
      end
    end
  end

  always @(posedge clk) if (div_start) starts <= starts + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[k]    = 1'b1;
    req_a[k*W +: W] = a;
    req_b[k*W +: W] = b;
  endtask

  task automatic wait_rsp(input string tag, output int n);
    n = 0;
    while (rsp_valid == '0 && n < 60) begin
      tick;
      n++;
    end
    if (rsp_valid == '0) begin
      total++;
      bad++;
      $error("FAIL %s: no rsp_valid got 0 want nonzero", tag);
    end
  endtask

  // Full transaction for requester k with rsp_ready high.
  task automatic serve(input int k, input int q, input int r, input int dbz, input string tag);
    int n;
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      tick;
      n++;
    end
    chk({tag, " gnt"}, 32'(req_ready), 32'(1 << k));
    tick;
    req_valid[k] = 1'b0;
    wait_rsp(tag, n);
    chk({tag, " vld"}, 32'(rsp_valid), 32'(1 << k));
    chk({tag, " quo"}, 32'(rsp_quo), 32'(q));
    chk({tag, " rem"}, 32'(rsp_rem), 32'(r));
    chk({tag, " dbz"}, 32'(rsp_dbz), 32'(dbz));
    chk({tag, " err"}, 32'(rsp_err), 32'd0);
    tick;
  endtask

  int n, s0;
  int q3[4] = '{200, 100, 66, 50};
  int r3[4] = '{0, 0, 2, 0};
  logic quiet;

  initial begin
    // reset state
    tick; tick;
    rstn = 1'b1;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst div_start", 32'(div_start), 32'd0);
    chk("rst div_a", 32'(div_a), 32'd0);
    chk("rst div_b", 32'(div_b), 32'd0);
    chk("rst quo", 32'(rsp_quo), 32'd0);
    chk("rst rem", 32'(rsp_rem), 32'd0);
    chk("rst dbz_err", {30'd0, rsp_dbz, rsp_err}, 32'd0);
    tick;

    // single request, latency and start pulse width
    s0 = starts;
    set_req(1, 100, 7);
    #1;
    chk("t1 gnt", 32'(req_ready), 32'h2);
    tick;
    req_valid[1] = 1'b0;
    chk("t1 start", 32'(div_start), 32'd1);
    chk("t1 div_a", 32'(div_a), 32'd100);
    chk("t1 div_b", 32'(div_b), 32'd7);
    tick;
    n = 1;
    chk("t1 start width", 32'(div_start), 32'd0);
    while (rsp_valid == '0 && n < 40) begin
      tick;
      n++;
    end
    chk("t1 latency", 32'(n), 32'(W + 2));
    chk("t1 vld", 32'(rsp_valid), 32'h2);
    chk("t1 quo", 32'(rsp_quo), 32'd14);
    chk("t1 rem", 32'(rsp_rem), 32'd2);
    chk("t1 dbz", 32'(rsp_dbz), 32'd0);
    chk("t1 err", 32'(rsp_err), 32'd0);
    tick;
    chk("t1 release", 32'(rsp_valid), 32'd0);
    chk("t1 starts", 32'(starts - s0), 32'd1);

    // divide by zero
    s0 = starts;
    set_req(0, 55, 0);
    serve(0, 0, 0, 1, "t2");
    chk("t2 starts", 32'(starts - s0), 32'd1);

    // requester 3 leaves rr_ptr at 0
    set_req(3, 255, 16);
    serve(3, 15, 15, 0, "t3a");

    // all four requesting: round-robin order 0,1,2,3
    for (int k = 0; k < NREQ; k++) set_req(k, 200, W'(k + 1));
    for (int k = 0; k < NREQ; k++) serve(k, q3[k], r3[k], 0, $sformatf("t3 r%0d", k));

    // 2 and 0 together with rr_ptr=0
    set_req(2, 30, 4);
    set_req(0, 17, 5);
    serve(0, 3, 2, 0, "t3b r0");
    serve(2, 7, 2, 0, "t3b r2");

    // response back-pressure; non-owner rsp_ready bits high
    rsp_ready = 4'b1110;
    set_req(0, 20, 6);
    #1;
    chk("t4 gnt", 32'(req_ready), 32'h1);
    tick;
    req_valid[0] = 1'b0;
    req_a[7:0]   = 8'hFF;
    set_req(1, 9, 3);
    wait_rsp("t4", n);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4 hold%0d vld", i), 32'(rsp_valid), 32'h1);
      chk($sformatf("t4 hold%0d quo", i), 32'(rsp_quo), 32'd3);
      chk($sformatf("t4 hold%0d rem", i), 32'(rsp_rem), 32'd2);
      chk($sformatf("t4 hold%0d rdy", i), 32'(req_ready), 32'd0);
      chk($sformatf("t4 hold%0d start", i), 32'(div_start), 32'd0);
      chk($sformatf("t4 hold%0d div_a", i), 32'(div_a), 32'd20);
      tick;
    end
    rsp_ready = 4'b1111;
    tick;
    chk("t4 next gnt", 32'(req_ready), 32'h2);
    chk("t4 released", 32'(rsp_valid), 32'd0);
    serve(1, 3, 0, 0, "t4b");

    // reset while waiting on the divider
    set_req(2, 100, 3);
    #1;
    tick;
    req_valid[2] = 1'b0;
    tick; tick;
    chk("t5 in flight", 32'(div_a), 32'd100);
    rstn = 1'b0;
    tick;
    rstn = 1'b1;
    chk("t5 rst rdy", 32'(req_ready), 32'd0);
    chk("t5 rst vld", 32'(rsp_valid), 32'd0);
    chk("t5 rst start", 32'(div_start), 32'd0);
    chk("t5 rst div_a", 32'(div_a), 32'd0);
    chk("t5 rst div_b", 32'(div_b), 32'd0);
    chk("t5 rst quo", 32'(rsp_quo), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (rsp_valid != '0 || div_start) quiet = 1'b0;
      tick;
    end
    chk("t5 abandoned", 32'(quiet), 32'd1);
    set_req(2, 9, 3);
    serve(2, 3, 0, 0, "t5b");

`ifdef DIVARB_TIMEOUT_EN
    hang = 1'b1;
    set_req(1, 5, 1);
    #1;
    tick;
    req_valid[1] = 1'b0;
    n = 0;
    while (rsp_valid == '0 && n < 60) begin
      tick;
      n++;
    end
    chk("t6 tmo latency", 32'(n), 32'd21);
    chk("t6 vld", 32'(rsp_valid), 32'h2);
    chk("t6 err", 32'(rsp_err), 32'd1);
    chk("t6 quo", 32'(rsp_quo), 32'd0);
    chk("t6 rem", 32'(rsp_rem), 32'd0);
    chk("t6 dbz", 32'(rsp_dbz), 32'd0);
    tick;
    chk("t6 release", 32'(rsp_valid), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
